// File: rtl/dbg_pkg.sv
// dbg_pkg
// Shared definitions for the bus-trace logger:
//   HDR_TAG    - fixed top three bits of every record header byte
//   tx_state_t - states of the record serialiser
//   nb_bytes() - bytes per record for a given address/data width
package dbg_pkg;

  localparam logic [2:0] HDR_TAG = 3'b101;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WR,
    TX_GAP,
    TX_WAIT,
    TX_NEXT
  } tx_state_t;

  // Header byte, then address and data rounded up to whole bytes.
  function automatic int nb_bytes(input int addr_w, input int data_w);
    return 1 + (addr_w + 7) / 8 + (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous record FIFO, all state on the falling edge of clk.
// Read data is registered and only changes on a pop, so the popped record
// stays stable on rdata_o for as long as the consumer needs it.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, wdata_i write request and record; accepted if not full or popping
//   pop_i           read request; ignored when empty
//   rdata_o         record taken by the most recent pop
//   full_o, empty_o status flags
//   level_o         records currently held
module trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign full_o  = (lvl_q == LVL_W'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a write when a read frees a slot the same edge.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    lvl_d = lvl_q;
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // Storage array: no reset so it maps onto block RAM. On a simultaneous
  // push/pop at full the pointers coincide; the read returns the old entry.
  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
    if (do_pop)  rdata_q       <= mem[rd_ptr_q];
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      lvl_q <= lvl_d;
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/uart_txm.sv
// uart_txm
// 8N1 serial transmitter, LSB first, falling-edge clocked.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   we_i      load data_i and start a frame (ignored while busy)
//   data_i    byte to send
//   txe_o     transmitter empty, ready for the next byte
//   tx_o      serial line, idles high
module uart_txm #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [7:0] data_i,
  output logic       txe_o,
  output logic       tx_o
);

  localparam logic [15:0] DIV_LAST = 16'(CLKS_PER_BIT - 1);

  logic [9:0]  shift_q, shift_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] div_q, div_d;
  logic        busy_q, busy_d;

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    busy_d  = busy_q;
    if (!busy_q) begin
      if (we_i) begin
        shift_d = {1'b1, data_i, 1'b0};  // stop, data, start
        bit_d   = '0;
        div_d   = '0;
        busy_d  = 1'b1;
      end
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      shift_d = {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) busy_d = 1'b0;
      else               bit_d  = bit_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      shift_q <= '1;
      bit_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_o  = busy_q ? shift_q[0] : 1'b1;
  assign txe_o = ~busy_q;

endmodule

// File: rtl/dbg_trace.sv
// dbg_trace
// Bus-trace logger: captures CPU accesses that fall in one of NWIN address
// windows, queues fixed-format records and sends them byte by byte (header,
// address MSB-first, data MSB-first) through uart_txm. All logic runs on the
// falling edge of clk.
// Build option: define DBG_TRACE_HALT_EN to drive halt when the FIFO holds
// DEPTH-1 or more records; otherwise halt is tied low.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   bus_sync                     one-cycle strobe qualifying bus sampling
//   bus_addr, bus_do, bus_di     address, write data, read data
//   bus_as, bus_oe,
//   bus_we_lo, bus_we_hi         active-low bus strobes
//   trace_en                     capture enable (queued records still drain)
//   win_en, win_base, win_mask   per-window enable, base and compare mask
//   halt                         CPU halt request
//   uart_tx                      serial output
//   fifo_lvl                     records queued
//   ovf_cnt                      dropped records, saturating
module dbg_trace
  import dbg_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int NWIN     = 4,
  parameter int DEPTH    = 16,
  parameter int BAUD_DIV = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bus_sync,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic [DATA_W-1:0]        bus_do,
  input  logic [DATA_W-1:0]        bus_di,
  input  logic                     bus_as,
  input  logic                     bus_oe,
  input  logic                     bus_we_lo,
  input  logic                     bus_we_hi,
  input  logic                     trace_en,
  input  logic [NWIN-1:0]          win_en,
  input  logic [NWIN*ADDR_W-1:0]   win_base,
  input  logic [NWIN*ADDR_W-1:0]   win_mask,
  output logic                     halt,
  output logic                     uart_tx,
  output logic [$clog2(DEPTH):0]   fifo_lvl,
  output logic [15:0]              ovf_cnt
);

  localparam int AB    = (ADDR_W + 7) / 8;
  localparam int DB    = (DATA_W + 7) / 8;
  localparam int NB    = nb_bytes(ADDR_W, DATA_W);
  localparam int REC_W = 8 * NB;

  // ---------------- address match ----------------
  logic [NWIN-1:0] win_hit;
  logic [1:0]      win_idx;
  logic            hit;

  for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
    assign win_hit[gi] = win_en[gi] &
      (((bus_addr ^ win_base[gi*ADDR_W +: ADDR_W]) & win_mask[gi*ADDR_W +: ADDR_W]) == '0);
  end

  // Walk from the top so the lowest matching window is left in win_idx.
  always_comb begin
    win_idx = 2'd0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      if (win_hit[i]) win_idx = 2'(i);
    end
  end
  assign hit = |win_hit;

  // ---------------- capture ----------------
  logic             access, rd, cap, drop;
  logic             armed_q, armed_d;
  logic [7:0]       hdr;
  logic [8*AB-1:0]  addr_pad;
  logic [8*DB-1:0]  data_pad;
  logic [REC_W-1:0] rec_in;

  assign access = ~bus_as & (~bus_oe | ~bus_we_lo | ~bus_we_hi);
  assign rd     = ~bus_oe;
  // armed keeps a long access (several sync strobes) down to one record.
  assign cap    = bus_sync & trace_en & access & hit & armed_q;
  assign hdr    = {HDR_TAG, rd, ~bus_we_hi, ~bus_we_lo, win_idx};

  always_comb begin
    addr_pad = '0;
    addr_pad[ADDR_W-1:0] = bus_addr;
    data_pad = '0;
    data_pad[DATA_W-1:0] = rd ? bus_di : bus_do;
    rec_in = {hdr, addr_pad, data_pad};
  end

  always_comb begin
    armed_d = armed_q;
    if (bus_as)   armed_d = 1'b1;
    else if (cap) armed_d = 1'b0;
  end

  // ---------------- FIFO ----------------
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [REC_W-1:0] rec_rd;
  logic [15:0]      ovf_q, ovf_d;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap),
    .wdata_i (rec_in),
    .pop_i   (fifo_pop),
    .rdata_o (rec_rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  assign drop = cap & fifo_full & ~fifo_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 1'b1;
  end

  // ---------------- serialiser ----------------
  tx_state_t  state_q, state_d;
  logic [3:0] byte_ctr_q, byte_ctr_d;
  logic       txe_q;
  logic       uart_we, uart_txe;
  logic [7:0] uart_byte;
  logic [7:0] rec_bytes [16];

  // Byte k of the popped record, header first; slots past NB read as zero.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    if (gi < NB) begin : g_used
      assign rec_bytes[gi] = rec_rd[REC_W-1-8*gi -: 8];
    end else begin : g_pad
      assign rec_bytes[gi] = 8'h00;
    end
  end
  assign uart_byte = rec_bytes[byte_ctr_q];

  // GAP gives txe_q time to see the UART go busy before WAIT looks at it.
  always_comb begin
    state_d    = state_q;
    byte_ctr_d = byte_ctr_q;
    fifo_pop   = 1'b0;
    uart_we    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          byte_ctr_d = '0;
          state_d    = TX_WR;
        end
      end
      TX_WR: begin
        uart_we = 1'b1;
        state_d = TX_GAP;
      end
      TX_GAP:  state_d = TX_WAIT;
      TX_WAIT: if (txe_q) state_d = TX_NEXT;
      TX_NEXT: begin
        if (byte_ctr_q == 4'(NB - 1)) begin
          state_d = TX_IDLE;
        end else begin
          byte_ctr_d = byte_ctr_q + 1'b1;
          state_d    = TX_WR;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  uart_txm #(
    .CLKS_PER_BIT (BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .we_i   (uart_we),
    .data_i (uart_byte),
    .txe_o  (uart_txe),
    .tx_o   (uart_tx)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      armed_q    <= 1'b1;
      ovf_q      <= '0;
      state_q    <= TX_IDLE;
      byte_ctr_q <= '0;
      txe_q      <= 1'b1;
    end else begin
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      byte_ctr_q <= byte_ctr_d;
      txe_q      <= uart_txe;
    end
  end

  assign ovf_cnt = ovf_q;

`ifdef DBG_TRACE_HALT_EN
  logic halt_q;
  always_ff @(negedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= (fifo_lvl >= ($clog2(DEPTH)+1)'(DEPTH - 1));
  end
  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_trace.sv
module tb_dbg_trace;

  localparam int BAUD = 4;

  logic        clk, rst, bus_sync;
  logic [23:0] bus_addr;
  logic [15:0] bus_do, bus_di;
  logic        bus_as, bus_oe, bus_we_lo, bus_we_hi, trace_en;
  logic [3:0]  win_en;
  logic [95:0] win_base, win_mask;
  logic        halt, uart_tx;
  logic [2:0]  fifo_lvl;
  logic [15:0] ovf_cnt;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] rx_q [$];

  dbg_trace #(
    .ADDR_W   (24),
    .DATA_W   (16),
    .NWIN     (4),
    .DEPTH    (4),
    .BAUD_DIV (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_sync  (bus_sync),
    .bus_addr  (bus_addr),
    .bus_do    (bus_do),
    .bus_di    (bus_di),
    .bus_as    (bus_as),
    .bus_oe    (bus_oe),
    .bus_we_lo (bus_we_lo),
    .bus_we_hi (bus_we_hi),
    .trace_en  (trace_en),
    .win_en    (win_en),
    .win_base  (win_base),
    .win_mask  (win_mask),
    .halt      (halt),
    .uart_tx   (uart_tx),
    .fifo_lvl  (fifo_lvl),
    .ovf_cnt   (ovf_cnt)
  );

  // DUT acts on negedge; bench drives and samples on posedge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Serial receiver: 8N1, LSB first, sampling mid-bit.
  initial begin
    logic [7:0] v;
    forever begin
      @(posedge clk);
      if (uart_tx === 1'b0) begin
        repeat (BAUD / 2) @(posedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (BAUD) @(posedge clk);
          v[b] = uart_tx;
        end
        repeat (BAUD) @(posedge clk);
        rx_q.push_back(v);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus access: strobes low with sync for one cycle, then released.
  task automatic acc(input logic [23:0] a, input logic oe, input logic lo,
                     input logic hi, input logic [15:0] d);
    @(posedge clk);
    bus_addr  = a;
    bus_as    = 1'b0;
    bus_oe    = oe;
    bus_we_lo = lo;
    bus_we_hi = hi;
    bus_do    = oe ? d : 16'hDEAD;
    bus_di    = oe ? 16'hDEAD : d;
    bus_sync  = 1'b1;
    @(posedge clk);
    bus_sync  = 1'b0;
    bus_as    = 1'b1;
    bus_oe    = 1'b1;
    bus_we_lo = 1'b1;
    bus_we_hi = 1'b1;
  endtask

  task automatic expect_rec(input string tag, input logic [47:0] exp);
    int n;
    n = 0;
    while (rx_q.size() < 6 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("%s.have6", tag), 32'(rx_q.size() >= 6), 32'd1);
    if (rx_q.size() < 6) return;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s.byte%0d", tag, k), 32'(rx_q.pop_front()), 32'(exp[47-8*k -: 8]));
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    repeat (cycles) @(posedge clk);
    chk(tag, 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus_sync  = 1'b0;
    bus_addr  = '0;
    bus_do    = '0;
    bus_di    = '0;
    bus_as    = 1'b1;
    bus_oe    = 1'b1;
    bus_we_lo = 1'b1;
    bus_we_hi = 1'b1;
    trace_en  = 1'b0;
    win_en    = '0;
    win_base  = '0;
    win_mask  = '0;

    repeat (3) @(posedge clk);
    chk("rst.lvl",  32'(fifo_lvl), 32'd0);
    chk("rst.ovf",  32'(ovf_cnt),  32'd0);
    chk("rst.halt", 32'(halt),     32'd0);
    chk("rst.tx",   32'(uart_tx),  32'd1);
    rst = 1'b0;

    // Window 3 would match everything but stays disabled.
    win_base = {24'h000000, 24'h123400, 24'h120000, 24'hFF8000};
    win_mask = {24'h000000, 24'hFFFF00, 24'hFF0000, 24'hFFFF00};
    win_en   = 4'b0111;
    trace_en = 1'b1;

    // Word write in window 0: hdr 101_0_1_1_00.
    acc(24'hFF8002, 1'b1, 1'b0, 1'b0, 16'h1234);
    chk("wr.lvl", 32'(fifo_lvl), 32'd1);
    expect_rec("wr", 48'hAC_FF8002_1234);

    // Read with address strobe held over three sync pulses: one record.
    @(posedge clk);
    bus_addr = 24'hFF8004; bus_as = 1'b0; bus_oe = 1'b0; bus_di = 16'hBEEF; bus_sync = 1'b1;
    @(posedge clk); bus_sync = 1'b0;
    @(posedge clk); bus_sync = 1'b1;
    @(posedge clk); bus_sync = 1'b0;
    @(posedge clk); bus_sync = 1'b1;
    @(posedge clk); bus_sync = 1'b0; bus_as = 1'b1; bus_oe = 1'b1;
    chk("rd.lvl", 32'(fifo_lvl), 32'd0);
    expect_rec("rd", 48'hB0_FF8004_BEEF);
    expect_quiet("rd.single", 300);

    // Windows 1 and 2 both match; lower index wins. Low-byte write.
    acc(24'h123456, 1'b1, 1'b0, 1'b1, 16'h55AB);
    expect_rec("ovl", 48'hA5_123456_55AB);

    // Outside every enabled window.
    acc(24'h500000, 1'b1, 1'b0, 1'b0, 16'h7777);
    chk("miss.lvl", 32'(fifo_lvl), 32'd0);
    expect_quiet("miss.quiet", 300);

    // Overflow: first record goes straight to the UART, four queue, two drop.
    for (int i = 0; i < 7; i++) acc(24'hFF8010 + 24'(i), 1'b1, 1'b0, 1'b0, 16'(i));
    chk("ovf.lvl", 32'(fifo_lvl), 32'd4);
    chk("ovf.cnt", 32'(ovf_cnt),  32'd2);
`ifdef DBG_TRACE_HALT_EN
    chk("ovf.halt", 32'(halt), 32'd1);
`else
    chk("ovf.halt", 32'(halt), 32'd0);
`endif
    for (int i = 0; i < 5; i++)
      expect_rec($sformatf("ovf.rec%0d", i), {8'hAC, 24'hFF8010 + 24'(i), 16'(i)});
    chk("ovf.drained", 32'(fifo_lvl), 32'd0);
    expect_quiet("ovf.quiet", 300);

    // Reset in the middle of a record with another one queued.
    acc(24'hFF8020, 1'b1, 1'b0, 1'b0, 16'hAAAA);
    acc(24'hFF8021, 1'b1, 1'b0, 1'b0, 16'hBBBB);
    repeat (100) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    chk("mrst.tx",  32'(uart_tx),  32'd1);
    chk("mrst.lvl", 32'(fifo_lvl), 32'd0);
    chk("mrst.ovf", 32'(ovf_cnt),  32'd0);
    repeat (60) @(posedge clk);
    rx_q.delete();
    acc(24'hFF8030, 1'b1, 1'b0, 1'b0, 16'hCCCC);
    expect_rec("mrst.new", 48'hAC_FF8030_CCCC);
    expect_quiet("mrst.quiet", 300);

    // Disable capture with records pending: they drain, new hits ignored.
    for (int i = 0; i < 3; i++) acc(24'hFF80A0 + 24'(i), 1'b1, 1'b0, 1'b0, 16'hD000 + 16'(i));
    trace_en = 1'b0;
    acc(24'hFF80B0, 1'b1, 1'b0, 1'b0, 16'hE000);
    acc(24'hFF80B1, 1'b1, 1'b0, 1'b0, 16'hE001);
    chk("ten.lvl", 32'(fifo_lvl), 32'd2);
    for (int i = 0; i < 3; i++)
      expect_rec($sformatf("ten.rec%0d", i), {8'hAC, 24'hFF80A0 + 24'(i), 16'hD000 + 16'(i)});
    expect_quiet("ten.quiet", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
